rate_bcd_counter: RTL and testbench

Event-rate meter that sits between the line-drawing engine and the six-digit hex display on the DE0-CV line benchmark. It counts single-cycle "line done" events over a fixed window of COUNT_PERIOD clocks (one second at the line clock), snapshots the total and converts it to six packed BCD digits. The result drives the 24-bit display bus directly, so HEX5..HEX0 read lines per second in decimal.

---
 rtl/rate_bcd_pkg.sv | 22 ++
 rtl/bin2bcd_seq.sv | 65 ++++++
 rtl/rate_bcd_counter.sv | 94 +++++++++
 tb/tb_rate_bcd_counter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rate_bcd_pkg.sv
// rtl/rate_bcd_pkg.sv - shared constants, converter FSM type and BCD digit helper
package rate_bcd_pkg;

  localparam int BIN_W  = 20;
  localparam int DIGITS = 6;
  localparam int BCD_W  = 24;
  localparam int STEP_W = 5;

  localparam logic [BIN_W-1:0]  BCD_MAX   = 20'd999999;
  localparam logic [STEP_W-1:0] STEP_LAST = 5'(BIN_W - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } conv_state_e;

  // Double-dabble digit correction: a digit of 5 or more would overflow past 9 once doubled
  function automatic logic [3:0] add3(input logic [3:0] digit);
    return (digit >= 4'd5) ? digit + 4'd3 : digit;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble converter, one shift-and-add-3 step per cycle
module bin2bcd_seq
  import rate_bcd_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic [BCD_W-1:0] bcd,
  output logic             done
);

  conv_state_e       state;
  logic [STEP_W-1:0] step;
  logic [BIN_W-1:0]  bin_sr;
  logic [BCD_W-1:0]  scratch;
  logic [BCD_W-1:0]  adjusted;
  logic [BCD_W-1:0]  stepped;

  // One conversion step: correct every digit, then shift the next binary bit in
  always_comb begin
    adjusted = '0;
    for (int i = 0; i < DIGITS; i++) begin
      adjusted[i*4 +: 4] = add3(scratch[i*4 +: 4]);
    end
    stepped = {adjusted[BCD_W-2:0], bin_sr[BIN_W-1]};
  end

  // The last step's result is presented directly so the caller can register it on the final edge
  assign bcd  = stepped;
  assign done = (state == CONVERT) && (step == STEP_LAST);

  // IDLE waits for start; CONVERT runs BIN_W steps and returns to IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      step    <= '0;
      bin_sr  <= '0;
      scratch <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bin_sr  <= bin;
            scratch <= '0;
            step    <= '0;
            state   <= CONVERT;
          end
        end
        CONVERT: begin
          scratch <= stepped;
          bin_sr  <= {bin_sr[BIN_W-2:0], 1'b0};
          if (step == STEP_LAST) begin
            step  <= '0;
            state <= IDLE;
          end else begin
            step <= step + 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/rate_bcd_counter.sv
// rtl/rate_bcd_counter.sv - counts events per fixed window and reports the total as six BCD digits
module rate_bcd_counter
  import rate_bcd_pkg::*;
#(
  parameter logic [31:0] COUNT_PERIOD = 32'd50000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             event_in,
  output logic [BCD_W-1:0] count,
  output logic             count_valid,
  output logic             overflow
);

  // A window shorter than one full conversion would restart the converter mid-flight
  if (COUNT_PERIOD < 32'd32) begin : g_period_check
    $error("rate_bcd_counter: COUNT_PERIOD must be at least 32");
  end

  logic [31:0]      period_cnt;
  logic             terminal;
  logic [BIN_W-1:0] acc;
  logic [BIN_W-1:0] acc_next;
  logic             sat;
  logic             sat_next;
  logic             ovf_hold;
  logic [BCD_W-1:0] conv_bcd;
  logic             conv_done;

  assign terminal = (period_cnt == COUNT_PERIOD - 32'd1);

  // Saturating next count; it includes this cycle's event so a terminal-cycle event lands in the snapshot
  always_comb begin
    acc_next = acc;
    if (event_in && (acc != BCD_MAX)) begin
      acc_next = acc + 20'd1;
    end
    sat_next = sat | (acc_next == BCD_MAX);
  end

  // Window position, wrapping with no gap so every window is exactly COUNT_PERIOD cycles
  always_ff @(posedge clk) begin
    if (reset || terminal) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + 32'd1;
    end
  end

  // Event accumulator and saturation flag restart at the start of each window
  always_ff @(posedge clk) begin
    if (reset || terminal) begin
      acc <= '0;
      sat <= 1'b0;
    end else begin
      acc <= acc_next;
      sat <= sat_next;
    end
  end

  // Saturation of the ending window is held until its conversion completes
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_hold <= 1'b0;
    end else if (terminal) begin
      ovf_hold <= sat_next;
    end
  end

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (terminal),
    .bin   (acc_next),
    .bcd   (conv_bcd),
    .done  (conv_done)
  );

  // Outputs change only when a conversion finishes, so intermediate steps never show
  always_ff @(posedge clk) begin
    if (reset) begin
      count       <= '0;
      count_valid <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      count_valid <= conv_done;
      if (conv_done) begin
        count    <= conv_bcd;
        overflow <= ovf_hold;
      end
    end
  end

endmodule

// File: tb/tb_rate_bcd_counter.sv
// tb/tb_rate_bcd_counter.sv - randomized self-checking bench for rate_bcd_counter against a window-count model
module tb_rate_bcd_counter;

  localparam int PERIOD = 64;
  localparam int LAT    = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        event_in = 1'b0;
  logic [23:0] count;
  logic        count_valid;
  logic        overflow;

  int tests = 0;
  int fails = 0;

  rate_bcd_counter #(.COUNT_PERIOD(32'd64)) dut (
    .clk         (clk),
    .reset       (reset),
    .event_in    (event_in),
    .count       (count),
    .count_valid (count_valid),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Decimal digits of v packed four bits each
  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < 6; i++) begin
      r[i*4 +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // Model: count events per window, report min(total, 999999) LAT edges after the window closes
  int          m_pos = 0;
  int          m_total = 0;
  longint      m_edge = 0;
  longint      m_due = -1;
  int          m_pend_val = 0;
  logic        m_pend_ovf = 1'b0;
  logic        exp_valid = 1'b0;
  logic [23:0] exp_count = '0;
  logic        exp_ovf = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_pos = 0;
      m_total = 0;
      m_due = -1;
      exp_valid = 1'b0;
      exp_count = '0;
      exp_ovf = 1'b0;
    end else begin
      m_edge = m_edge + 1;
      exp_valid = 1'b0;
      if (m_due == m_edge) begin
        exp_valid = 1'b1;
        exp_count = to_bcd(m_pend_val);
        exp_ovf = m_pend_ovf;
        m_due = -1;
      end
      m_total = m_total + (event_in ? 1 : 0);
      m_pos = m_pos + 1;
      if (m_pos == PERIOD) begin
        m_pend_val = (m_total > 999999) ? 999999 : m_total;
        m_pend_ovf = (m_total >= 999999);
        m_due = m_edge + LAT;
        m_total = 0;
        m_pos = 0;
      end
    end
  end

  // Compare process: DUT outputs against the model every cycle, and capture reported results
  bit          chk_en = 1'b0;
  int          n_cap = 0;
  logic [23:0] last_count = '0;
  logic        last_ovf = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      tests = tests + 3;
      if (count_valid !== exp_valid) begin
        fails++;
        $display("FAIL cyc_valid t=%0t got %b want %b", $time, count_valid, exp_valid);
      end
      if (count !== exp_count) begin
        fails++;
        $display("FAIL cyc_count t=%0t got %h want %h", $time, count, exp_count);
      end
      if (overflow !== exp_ovf) begin
        fails++;
        $display("FAIL cyc_overflow t=%0t got %b want %b", $time, overflow, exp_ovf);
      end
    end
    if (count_valid === 1'b1) begin
      n_cap++;
      last_count = count;
      last_ovf = overflow;
    end
  end

  int seen_cap = 0;

  task automatic check_last(input string name, input logic [23:0] want_count, input logic want_ovf);
    tests = tests + 3;
    if (n_cap <= seen_cap) begin
      fails++;
      $display("FAIL %s_pulse got %0d results want more than %0d", name, n_cap, seen_cap);
    end
    seen_cap = n_cap;
    if (last_count !== want_count) begin
      fails++;
      $display("FAIL %s_count got %h want %h", name, last_count, want_count);
    end
    if (last_ovf !== want_ovf) begin
      fails++;
      $display("FAIL %s_overflow got %b want %b", name, last_ovf, want_ovf);
    end
  endtask

  function automatic logic [63:0] pick(input int k, input int lo);
    logic [63:0] p;
    int n;
    int b;
    p = '0;
    n = 0;
    while (n < k) begin
      b = int'($urandom_range(63, lo));
      if (!p[b]) begin
        p[b] = 1'b1;
        n++;
      end
    end
    return p;
  endfunction

  // Drives one full window starting at the negedge before its first cycle
  task automatic drive_window(input logic [63:0] pat, input bit preload);
    for (int c = 0; c < PERIOD; c++) begin
      if (preload && c == 0) begin
        force dut.acc = 20'd999998;
        m_total = 999998;
      end
      if (preload && c == 1) begin
        release dut.acc;
      end
      event_in = pat[c];
      @(negedge clk);
    end
  endtask

  initial begin
    int          pulse_at;
    logic [23:0] cnt_at;
    logic [63:0] pat;

    reset = 1'b1;
    event_in = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;

    tests = tests + 3;
    if (count !== 24'h000000) begin fails++; $display("FAIL reset_count got %h want 000000", count); end
    if (count_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", count_valid); end
    if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got %b want 0", overflow); end

    reset = 1'b0;
    drive_window('0, 1'b0);
    drive_window(pick(37, 0), 1'b0);
    check_last("zero_window", 24'h000000, 1'b0);
    drive_window(pick(5, 2), 1'b1);
    check_last("events_37", 24'h000037, 1'b0);
    drive_window(pick(12, 0), 1'b0);
    check_last("saturate", 24'h999999, 1'b1);
    pat = '0;
    pat[63] = 1'b1;
    drive_window(pat, 1'b0);
    check_last("after_saturate", 24'h000012, 1'b0);
    drive_window('0, 1'b0);
    check_last("terminal_event", 24'h000001, 1'b0);
    drive_window('1, 1'b0);
    check_last("after_terminal", 24'h000000, 1'b0);
    drive_window('1, 1'b0);
    check_last("full_window_a", 24'h000064, 1'b0);
    drive_window('0, 1'b0);
    check_last("full_window_b", 24'h000064, 1'b0);

    for (int w = 0; w < 6; w++) begin
      pat = {$urandom, $urandom};
      if (w % 2 == 1) pat = pat & {$urandom, $urandom};
      drive_window(pat, 1'b0);
    end

    // Reset lands on conversion step 10 of the previous window's result
    drive_window(pick(20, 0), 1'b0);
    for (int c = 0; c < 10; c++) begin
      event_in = 1'b0;
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    tests++;
    if (count !== 24'h000000) begin fails++; $display("FAIL midconv_count got %h want 000000", count); end

    pat = pick(23, 0);
    pulse_at = -1;
    cnt_at = '0;
    for (int k = 0; k < 2 * PERIOD; k++) begin
      if (count_valid === 1'b1 && pulse_at < 0) begin
        pulse_at = k;
        cnt_at = count;
      end
      event_in = (k < PERIOD) ? pat[k] : 1'b0;
      @(negedge clk);
    end
    tests = tests + 2;
    if (pulse_at != PERIOD + LAT) begin
      fails++;
      $display("FAIL midconv_latency got %0d want %0d", pulse_at, PERIOD + LAT);
    end
    if (cnt_at !== 24'h000023) begin
      fails++;
      $display("FAIL midconv_result got %h want 000023", cnt_at);
    end

    drive_window('0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
